matrix_add_sched: RTL and testbench
===================================

MATRIX_ADD_SCHED -- requirements
Module: matrix_add_sched

Interface
REQ-001 The block SHALL use clock clk; reset reset, asynchronous, active-high.
REQ-002 Parameter ADDR_W, default 16: width of element index, length and address fields.
REQ-003 Parameter CREDITS, default 8: maximum adds in flight; SHALL be >= 1 and match the downstream result FIFO depth.
REQ-004 Port clk  input  1  clock.
REQ-005 Port reset  input  1  asynchronous active-high reset.
REQ-006 Port start  input  1  one-cycle job start request.
REQ-007 Port len  input  ADDR_W  element count, sampled on accepted start.
REQ-008 Port busy  output  1  job active.
REQ-009 Port done  output  1  one-cycle job-complete pulse.
REQ-010 Port err  output  1  sticky protocol error flag.
REQ-011 Port rd_en / rd_addr  output  1 / ADDR_W  operand read request and index to A/B memories; data is returned one cycle later.
REQ-012 Port rd_a, rd_b  input  32 each  operand data, valid the cycle after rd_en.
REQ-013 Port add_start, add_a, add_b  output  1, 32, 32  adder issue and operands.
REQ-014 Port add_done, add_result  input  1, 32  in-order adder completion pulse and sum.
REQ-015 Port wr_en, wr_addr, wr_data  output  1, ADDR_W, 32  result write to C memory.
REQ-016 Port stall_cnt  output  32  credit-stall cycle count (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, RUN and DRAIN; busy SHALL be 1 exactly when the state is not IDLE.
REQ-018 IDLE with start=1 and len!=0 SHALL latch len, clear the issue/write indices, and enter RUN next cycle.
REQ-019 IDLE with start=1 and len=0 SHALL stay in IDLE, issue no reads, and pulse done the next cycle.
REQ-020 start while busy SHALL be ignored without changing job state or err.
REQ-021 In RUN, rd_en SHALL be 1 in a cycle iff issued<len and inflight<CREDITS; rd_addr SHALL equal issued, and issued SHALL increment on each rd_en.
REQ-022 add_start SHALL be asserted exactly one cycle after each rd_en, with add_a=rd_a and add_b=rd_b from that cycle.
REQ-023 inflight SHALL increment on rd_en and decrement on add_done, stay unchanged when both occur, and never exceed CREDITS.
REQ-024 RUN SHALL go to DRAIN the cycle after the rd_en that makes issued equal to len.
REQ-025 Each add_done SHALL produce registered wr_en next cycle, with wr_data=add_result and wr_addr=written; written SHALL then increment.
REQ-026 When the wr_en with written=len-1 is asserted, the FSM SHALL go to IDLE next cycle and pulse done for one cycle in that cycle.
REQ-027 Minimum latency: len=1 with a 1-cycle adder gives start(T0), rd_en T1, add_start T2, add_done T3, wr_en T4, done T5.
REQ-028 add_done while inflight=0, or in IDLE, SHALL set err and be otherwise ignored; err SHALL clear only on reset.
REQ-029 Index counters SHALL be ADDR_W wide; len=2^ADDR_W-1 SHALL complete without wrap-around.

Reset
REQ-030 Reset SHALL force IDLE and clear all counters.
REQ-031 Reset SHALL drive every output to 0: busy, done, err, rd_en, rd_addr, add_start, add_a, add_b, wr_en, wr_addr, wr_data and stall_cnt.
REQ-032 Reset mid-job SHALL abandon the job; add_done pulses arriving after reset release while in IDLE SHALL set err.

Configuration
REQ-033 With macro MATRIX_ADD_SCHED_STALL_CNT_EN defined, stall_cnt SHALL increment, saturating at 2^32-1, each RUN cycle where issued<len and inflight=CREDITS, and SHALL clear on accepted start.
REQ-034 Without MATRIX_ADD_SCHED_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-035 len=1, A[0]=5, B[0]=7, 1-cycle adder -> rd_en T1, add_start T2 (5,7), wr_en T4 with addr 0 and data 12, done T5, busy T1-T4.
REQ-036 len=20, CREDITS=8, adder latency 12 -> inflight peaks at 8 and never exceeds it; 20 writes at addr 0..19 with C[i]=A[i]+B[i]; single done pulse; stall_cnt>0 with the macro defined, 0 without it.
REQ-037 start with len=0 -> no rd_en, add_start or wr_en; done one cycle later; busy stays 0.
REQ-038 start pulsed again at the 3rd RUN cycle of a len=4 job -> ignored; exactly 4 writes; err=0.
REQ-039 Reset asserted after 3 of 10 writes -> all outputs 0 next cycle; a stray add_done after release sets err=1; a following len=2 job completes correctly with err still 1.
REQ-040 Simultaneous rd_en and add_done at inflight=CREDITS-1 -> inflight unchanged and issue continues without a bubble.

Source files
------------

// File: rtl/matrix_add_sched_if.sv
// Bundled job-control, operand-read, adder and result-write signals of the
// matrix_add_sched block. The slave modport is the scheduler's view; the
// master modport is the surrounding memories/adder/controller.
interface matrix_add_sched_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] len;
  logic              busy;
  logic              done;
  logic              err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_a;
  logic [31:0]       rd_b;
  logic              add_start;
  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic              add_done;
  logic [31:0]       add_result;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [31:0]       stall_cnt;

  modport master (
    output start, len, rd_a, rd_b, add_done, add_result,
    input  busy, done, err, rd_en, rd_addr, add_start, add_a, add_b,
           wr_en, wr_addr, wr_data, stall_cnt
  );

  modport slave (
    input  start, len, rd_a, rd_b, add_done, add_result,
    output busy, done, err, rd_en, rd_addr, add_start, add_a, add_b,
           wr_en, wr_addr, wr_data, stall_cnt
  );
endinterface

// File: rtl/matrix_add_sched.sv
// Credit-based scheduler for C[i] = A[i] + B[i] over an external pipelined
// adder. Reads are issued only while fewer than CREDITS adds are in flight so
// the downstream result FIFO can never overflow. Results return in order and
// are written back one cycle after each add_done.
//
// Optional feature: define MATRIX_ADD_SCHED_STALL_CNT_EN to build the
// saturating credit-stall counter on stall_cnt; otherwise stall_cnt is tied 0.
//
// state | meaning
// IDLE  | no job; waiting for start
// RUN   | issuing operand reads (credit permitting)
// DRAIN | all reads issued; waiting for the remaining results
module matrix_add_sched #(
  parameter int ADDR_W  = 16,
  parameter int CREDITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  matrix_add_sched_if.slave bus
);

  localparam int             IW       = $clog2(CREDITS + 1);
  localparam logic [IW-1:0]  CRED_MAX = IW'(CREDITS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] issued;
  logic [ADDR_W-1:0] written;
  logic [IW-1:0]     inflight;
  logic              add_start_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              done_q;
  logic              err_q;

  logic rd_fire, done_ok, done_bad, start_ok, start_zero, last_wr, last_rd;

  // Qualify the handshakes once so the FSM and datapath agree on them.
  always_comb begin
    start_ok   = (state == IDLE) && bus.start && (bus.len != '0);
    start_zero = (state == IDLE) && bus.start && (bus.len == '0);
    rd_fire    = (state == RUN) && (issued < len_q) && (inflight < CRED_MAX);
    last_rd    = rd_fire && (issued == len_q - ADDR_W'(1));
    // A completion with nothing outstanding, or outside a job, is a protocol error.
    done_ok    = bus.add_done && (state != IDLE) && (inflight != '0);
    done_bad   = bus.add_done && !done_ok;
    last_wr    = wr_en_q && (state != IDLE) && (wr_addr_q == len_q - ADDR_W'(1));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (last_rd)  state_nxt = DRAIN;
      DRAIN:   if (last_wr)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job counters, credit tracking, result write-back and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q       <= '0;
      issued      <= '0;
      written     <= '0;
      inflight    <= '0;
      add_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q  <= bus.len;
        issued <= '0;
      end else if (rd_fire) begin
        issued <= issued + ADDR_W'(1);
      end

      if (start_ok)     written <= '0;
      else if (done_ok) written <= written + ADDR_W'(1);

      // Simultaneous issue and completion leave the credit count unchanged.
      case ({rd_fire, done_ok})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase

      add_start_q <= rd_fire;
      wr_en_q     <= done_ok;
      if (done_ok) begin
        wr_addr_q <= written;
        wr_data_q <= bus.add_result;
      end

      done_q <= start_zero || last_wr;
      if (done_bad) err_q <= 1'b1;
    end
  end

`ifdef MATRIX_ADD_SCHED_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count cycles where work remains but every credit is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state == RUN) && (issued < len_q) && (inflight == CRED_MAX)
                 && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

  // Operands are only presented while add_start is high so the adder inputs
  // stay quiet (and zero in reset) between issues.
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rd_en     = rd_fire;
  assign bus.rd_addr   = issued;
  assign bus.add_start = add_start_q;
  assign bus.add_a     = add_start_q ? bus.rd_a : '0;
  assign bus.add_b     = add_start_q ? bus.rd_b : '0;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_matrix_add_sched.sv
// Directed testbench for matrix_add_sched: A/B memory model with one-cycle
// read latency, in-order adder model with programmable latency, and a
// negedge monitor logging every DUT event with its cycle number.
module tb_matrix_add_sched;
  localparam int AW = 16;
  localparam int CR = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 1;
  int stray_req  = 0;
  int stray_done = 0;

  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];

  matrix_add_sched_if #(.ADDR_W(AW)) bus ();

  matrix_add_sched #(.ADDR_W(AW), .CREDITS(CR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Monitor snapshots and event logs.
  logic          s_rd_en = 1'b0;
  logic [AW-1:0] s_rd_addr = '0;
  logic          s_add_start = 1'b0;
  logic [31:0]   s_sum = '0;
  int            infl_m = 0;
  int            rd_cyc_q[$], as_cyc_q[$], wr_cyc_q[$], done_cyc_q[$], busy_cyc_q[$], infl_q[$];
  logic [31:0]   as_a_q[$], as_b_q[$], wr_data_q[$];
  logic [AW-1:0] wr_addr_q[$];

  // Sample the DUT mid-cycle and log events.
  always @(negedge clk) begin
    int pre;
    s_rd_en     = bus.rd_en;
    s_rd_addr   = bus.rd_addr;
    s_add_start = bus.add_start;
    s_sum       = bus.add_a + bus.add_b;
    infl_q.push_back(infl_m);
    pre = infl_m;
    if (reset) begin
      infl_m = 0;
    end else begin
      if (bus.rd_en) begin rd_cyc_q.push_back(cyc); infl_m++; end
      if (bus.add_done && bus.busy && pre > 0) infl_m--;
      if (bus.add_start) begin
        as_cyc_q.push_back(cyc); as_a_q.push_back(bus.add_a); as_b_q.push_back(bus.add_b);
      end
      if (bus.wr_en) begin
        wr_cyc_q.push_back(cyc); wr_addr_q.push_back(bus.wr_addr); wr_data_q.push_back(bus.wr_data);
      end
      if (bus.done) done_cyc_q.push_back(cyc);
      if (bus.busy) busy_cyc_q.push_back(cyc);
    end
  end

  // Memory and adder models, driven just after each rising edge.
  int          due_q[$];
  logic [31:0] sum_q[$];
  always @(posedge clk) begin
    logic [31:0] na, nb;
    if (reset) begin
      due_q.delete(); sum_q.delete();
    end else if (s_add_start) begin
      due_q.push_back(cyc + lat); sum_q.push_back(s_sum);
    end
    if (!reset && s_rd_en) begin
      na = mem_a[s_rd_addr[5:0]]; nb = mem_b[s_rd_addr[5:0]];
    end else begin
      na = $urandom; nb = $urandom;
    end
    cyc++;
    #1;
    bus.rd_a = na;
    bus.rd_b = nb;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      bus.add_done = 1'b1; bus.add_result = sum_q[0];
      void'(due_q.pop_front()); void'(sum_q.pop_front());
    end else if (stray_req != stray_done) begin
      bus.add_done = 1'b1; bus.add_result = 32'h0; stray_done++;
    end else begin
      bus.add_done = 1'b0; bus.add_result = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      64'(bus.busy),      64'(0));
    chk({tag, "_done"},      64'(bus.done),      64'(0));
    chk({tag, "_err"},       64'(bus.err),       64'(0));
    chk({tag, "_rd_en"},     64'(bus.rd_en),     64'(0));
    chk({tag, "_rd_addr"},   64'(bus.rd_addr),   64'(0));
    chk({tag, "_add_start"}, 64'(bus.add_start), 64'(0));
    chk({tag, "_add_a"},     64'(bus.add_a),     64'(0));
    chk({tag, "_add_b"},     64'(bus.add_b),     64'(0));
    chk({tag, "_wr_en"},     64'(bus.wr_en),     64'(0));
    chk({tag, "_wr_addr"},   64'(bus.wr_addr),   64'(0));
    chk({tag, "_wr_data"},   64'(bus.wr_data),   64'(0));
    chk({tag, "_stall_cnt"}, 64'(bus.stall_cnt), 64'(0));
  endtask

  task automatic start_job(input int l, output int t0);
    @(posedge clk); #2;
    t0 = cyc; bus.start = 1'b1; bus.len = AW'(l);
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n_before, input int budget, input string tag);
    int k = 0;
    while (done_cyc_q.size() <= n_before && k < budget) begin
      @(negedge clk); k++;
    end
    chk({tag, "_finished"}, 64'(done_cyc_q.size() > n_before), 64'(1));
  endtask

  function automatic int max_infl(input int from);
    int m = 0;
    for (int i = from; i < infl_q.size(); i++) if (infl_q[i] > m) m = infl_q[i];
    return m;
  endfunction

  task automatic chk_writes(input string tag, input int from, input int n);
    logic [31:0] e;
    chk({tag, "_n_wr"}, 64'(wr_cyc_q.size() - from), 64'(n));
    for (int i = 0; i < n; i++) begin
      e = mem_a[i] + mem_b[i];
      chk($sformatf("%s_wr_addr%0d", tag, i), 64'(wr_addr_q[from + i]), 64'(i));
      chk($sformatf("%s_wr_data%0d", tag, i), 64'(wr_data_q[from + i]), 64'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, brd, bas, bwr, bdn, bbz, bin, k;
    bus.start = 1'b0;
    bus.len   = '0;
    for (int i = 0; i < 64; i++) begin mem_a[i] = 32'h0; mem_b[i] = 32'h0; end

    // Reset values.
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk); #2; reset = 1'b0;

    // len=1, 1-cycle adder: minimum-latency timing.
    mem_a[0] = 32'd5; mem_b[0] = 32'd7; lat = 1;
    brd = rd_cyc_q.size(); bas = as_cyc_q.size(); bwr = wr_cyc_q.size();
    bdn = done_cyc_q.size(); bbz = busy_cyc_q.size();
    start_job(1, t0);
    wait_done(bdn, 50, "t1");
    repeat (3) @(negedge clk);
    chk("t1_n_rd",    64'(rd_cyc_q.size() - brd),   64'(1));
    chk("t1_rd_cyc",  64'(rd_cyc_q[brd] - t0),      64'(1));
    chk("t1_as_cyc",  64'(as_cyc_q[bas] - t0),      64'(2));
    chk("t1_add_a",   64'(as_a_q[bas]),             64'(5));
    chk("t1_add_b",   64'(as_b_q[bas]),             64'(7));
    chk("t1_wr_cyc",  64'(wr_cyc_q[bwr] - t0),      64'(4));
    chk("t1_wr_addr", 64'(wr_addr_q[bwr]),          64'(0));
    chk("t1_wr_data", 64'(wr_data_q[bwr]),          64'(12));
    chk("t1_done_cyc",64'(done_cyc_q[bdn] - t0),    64'(5));
    chk("t1_n_done",  64'(done_cyc_q.size() - bdn), 64'(1));
    chk("t1_busy_n",  64'(busy_cyc_q.size() - bbz), 64'(4));
    chk("t1_busy_1st",64'(busy_cyc_q[bbz] - t0),    64'(1));

    // len=20, latency 12: credit limit reached, stalls occur.
    lat = 12;
    for (int i = 0; i < 20; i++) begin mem_a[i] = $urandom; mem_b[i] = $urandom; end
    bwr = wr_cyc_q.size(); bdn = done_cyc_q.size(); bin = infl_q.size();
    start_job(20, t0);
    wait_done(bdn, 500, "t2");
    repeat (4) @(negedge clk);
    chk_writes("t2", bwr, 20);
    chk("t2_n_done",   64'(done_cyc_q.size() - bdn), 64'(1));
    chk("t2_max_infl", 64'(max_infl(bin)),          64'(CR));
    chk("t2_busy_end", 64'(bus.busy),               64'(0));
    chk("t2_err",      64'(bus.err),                64'(0));
`ifdef MATRIX_ADD_SCHED_STALL_CNT_EN
    chk("t2_stall_pos", 64'(bus.stall_cnt > 0), 64'(1));
`else
    chk("t2_stall_zero", 64'(bus.stall_cnt), 64'(0));
`endif

    // len=20, latency 6: issue and completion coincide at CREDITS-1, no bubble.
    lat = 6;
    for (int i = 0; i < 20; i++) begin mem_a[i] = $urandom; mem_b[i] = $urandom; end
    brd = rd_cyc_q.size(); bwr = wr_cyc_q.size(); bdn = done_cyc_q.size(); bin = infl_q.size();
    start_job(20, t0);
    wait_done(bdn, 500, "t3");
    repeat (2) @(negedge clk);
    chk("t3_n_rd",     64'(rd_cyc_q.size() - brd),              64'(20));
    chk("t3_rd_span",  64'(rd_cyc_q[brd + 19] - rd_cyc_q[brd]), 64'(19));
    chk("t3_max_infl", 64'(max_infl(bin)),                      64'(CR - 1));
    chk("t3_stall",    64'(bus.stall_cnt),                      64'(0));
    chk_writes("t3", bwr, 20);

    // len=0: immediate done, nothing issued.
    brd = rd_cyc_q.size(); bas = as_cyc_q.size(); bwr = wr_cyc_q.size();
    bdn = done_cyc_q.size(); bbz = busy_cyc_q.size();
    start_job(0, t0);
    wait_done(bdn, 20, "t4");
    repeat (6) @(negedge clk);
    chk("t4_done_cyc", 64'(done_cyc_q[bdn] - t0),     64'(1));
    chk("t4_n_done",   64'(done_cyc_q.size() - bdn),  64'(1));
    chk("t4_n_rd",     64'(rd_cyc_q.size() - brd),    64'(0));
    chk("t4_n_as",     64'(as_cyc_q.size() - bas),    64'(0));
    chk("t4_n_wr",     64'(wr_cyc_q.size() - bwr),    64'(0));
    chk("t4_busy_n",   64'(busy_cyc_q.size() - bbz),  64'(0));

    // len=4 with a second start on the 3rd RUN cycle: ignored.
    lat = 1;
    for (int i = 0; i < 10; i++) begin mem_a[i] = 32'd100 + 32'(i); mem_b[i] = 32'd3 * 32'(i); end
    brd = rd_cyc_q.size(); bwr = wr_cyc_q.size(); bdn = done_cyc_q.size();
    @(posedge clk); #2; t0 = cyc; bus.start = 1'b1; bus.len = AW'(4);
    @(posedge clk); #2; bus.start = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2; bus.start = 1'b1; bus.len = AW'(9);
    @(posedge clk); #2; bus.start = 1'b0;
    wait_done(bdn, 50, "t5");
    repeat (20) @(negedge clk);
    chk_writes("t5", bwr, 4);
    chk("t5_n_rd",   64'(rd_cyc_q.size() - brd),   64'(4));
    chk("t5_n_done", 64'(done_cyc_q.size() - bdn), 64'(1));
    chk("t5_err",    64'(bus.err),                 64'(0));
    chk("t5_busy",   64'(bus.busy),                64'(0));

    // Reset mid-job, stray completion, then a fresh job.
    lat = 3;
    bwr = wr_cyc_q.size();
    start_job(10, t0);
    k = 0;
    while (wr_cyc_q.size() - bwr < 3 && k < 200) begin @(negedge clk); k++; end
    chk("t6_partial", 64'((wr_cyc_q.size() - bwr >= 3) && (wr_cyc_q.size() - bwr < 10)), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("t6");
    @(posedge clk); #2; reset = 1'b0;
    @(negedge clk);
    chk("t6_err_clr", 64'(bus.err), 64'(0));
    stray_req++;
    repeat (3) @(negedge clk);
    chk("t6_err_set", 64'(bus.err), 64'(1));
    mem_a[0] = 32'hFFFF_FFFF; mem_b[0] = 32'd2;
    mem_a[1] = 32'h1234_0000; mem_b[1] = 32'h0000_5678;
    bwr = wr_cyc_q.size(); bdn = done_cyc_q.size();
    start_job(2, t0);
    wait_done(bdn, 50, "t7");
    repeat (3) @(negedge clk);
    chk_writes("t7", bwr, 2);
    chk("t7_n_done", 64'(done_cyc_q.size() - bdn), 64'(1));
    chk("t7_err",    64'(bus.err),                 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
